// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters and walks each
// operation through issue, capture and response phases.
module alu_arbiter #(
    parameter int WIDTH = 7,
    parameter int OPW   = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req0_valid,
    input  logic             i_req1_valid,
    output logic             o_req0_ready,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic [OPW-1:0]   i_req0_op,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic [OPW-1:0]   i_req1_op,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [OPW-1:0]   o_alu_op,
    output logic             o_alu_en,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_flag_gt_zero,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_flag,
    output logic             o_busy,
    output logic [7:0]       o_ops_done
);

    // state | meaning
    // IDLE  | waiting for a request; ready is offered to the round-robin winner
    // EXEC  | operands presented to the ALU, alu_en high for this one cycle
    // CAPT  | ALU result valid; registered into the response at end of cycle
    // RESP  | response held on rsp_* until the consumer takes it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic             r_alu_en;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_flag;
    logic             r_busy;
    logic [7:0]       r_ops_done;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;

    // On a tie the requester that did not win last time is favoured.
    assign w_idle   = (r_state == IDLE);
    assign w_grant0 = w_idle && i_req0_valid && (!i_req1_valid || r_last_grant);
    assign w_grant1 = w_idle && i_req1_valid && (!i_req0_valid || !r_last_grant);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_alu_en     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flag   <= 1'b0;
            r_busy       <= 1'b0;
            r_ops_done   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_alu_a      <= w_grant1 ? i_req1_a  : i_req0_a;
                        r_alu_b      <= w_grant1 ? i_req1_b  : i_req0_b;
                        r_alu_op     <= w_grant1 ? i_req1_op : i_req0_op;
                        r_rsp_id     <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_alu_en     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_alu_en <= 1'b0;
                    r_state  <= CAPT;
                end
                CAPT: begin
                    r_rsp_result <= i_alu_result;
                    r_rsp_flag   <= i_alu_flag_gt_zero;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ops_done  <= r_ops_done + 8'd1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_req0_ready = w_grant0;
    assign o_req1_ready = w_grant1;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_op     = r_alu_op;
    assign o_alu_en     = r_alu_en;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_flag   = r_rsp_flag;
    assign o_busy       = r_busy;
    assign o_ops_done   = r_ops_done;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a registered ALU model
// and hand-written sequences for stall, mid-operation reset and counter wrap.
module tb_alu_arbiter;

    localparam int WIDTH = 7;
    localparam int OPW   = 3;

    logic             i_clk;
    logic             i_reset;
    logic             i_req0_valid, i_req1_valid;
    logic             o_req0_ready, o_req1_ready;
    logic [WIDTH-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic [OPW-1:0]   i_req0_op, i_req1_op;
    logic [WIDTH-1:0] o_alu_a, o_alu_b;
    logic [OPW-1:0]   o_alu_op;
    logic             o_alu_en;
    logic [WIDTH-1:0] i_alu_result;
    logic             i_alu_flag_gt_zero;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic             o_rsp_id;
    logic [WIDTH-1:0] o_rsp_result;
    logic             o_rsp_flag;
    logic             o_busy;
    logic [7:0]       o_ops_done;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_req0_valid       (i_req0_valid),
        .i_req1_valid       (i_req1_valid),
        .o_req0_ready       (o_req0_ready),
        .o_req1_ready       (o_req1_ready),
        .i_req0_a           (i_req0_a),
        .i_req0_b           (i_req0_b),
        .i_req0_op          (i_req0_op),
        .i_req1_a           (i_req1_a),
        .i_req1_b           (i_req1_b),
        .i_req1_op          (i_req1_op),
        .o_alu_a            (o_alu_a),
        .o_alu_b            (o_alu_b),
        .o_alu_op           (o_alu_op),
        .o_alu_en           (o_alu_en),
        .i_alu_result       (i_alu_result),
        .i_alu_flag_gt_zero (i_alu_flag_gt_zero),
        .o_rsp_valid        (o_rsp_valid),
        .i_rsp_ready        (i_rsp_ready),
        .o_rsp_id           (o_rsp_id),
        .o_rsp_result       (o_rsp_result),
        .o_rsp_flag         (o_rsp_flag),
        .o_busy             (o_busy),
        .o_ops_done         (o_ops_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ALU model: result valid the cycle after alu_en.
    logic [WIDTH-1:0] w_alu_comb;
    always_comb begin
        case (o_alu_op)
            3'd0:    w_alu_comb = o_alu_a + o_alu_b;
            3'd1:    w_alu_comb = o_alu_a - o_alu_b;
            3'd2:    w_alu_comb = o_alu_a & o_alu_b;
            3'd3:    w_alu_comb = o_alu_a | o_alu_b;
            3'd4:    w_alu_comb = o_alu_a ^ o_alu_b;
            default: w_alu_comb = o_alu_a;
        endcase
    end
    always @(posedge i_clk) begin
        if (o_alu_en) begin
            i_alu_result       <= w_alu_comb;
            i_alu_flag_gt_zero <= ($signed(w_alu_comb) > 0);
        end
    end

    typedef struct {
        logic             v0, v1;
        logic [WIDTH-1:0] a0, b0;
        logic [OPW-1:0]   op0;
        logic [WIDTH-1:0] a1, b1;
        logic [OPW-1:0]   op1;
        logic             exp_id;
        logic [WIDTH-1:0] exp_res;
        logic             exp_flag;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_ops = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        i_req0_valid = v.v0;  i_req1_valid = v.v1;
        i_req0_a = v.a0; i_req0_b = v.b0; i_req0_op = v.op0;
        i_req1_a = v.a1; i_req1_b = v.b1; i_req1_op = v.op1;
    endtask

    // Entered at a negedge while the DUT is idle and rsp_ready is high.
    task automatic run_op(input vec_t v);
        drive(v);
        #1;
        chk("req0_ready", {31'd0, o_req0_ready}, {31'd0, v.exp_id == 1'b0});
        chk("req1_ready", {31'd0, o_req1_ready}, {31'd0, v.exp_id == 1'b1});
        @(posedge i_clk);
        @(negedge i_clk);
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        chk("exec_alu_en", {31'd0, o_alu_en}, 32'd1);
        chk("exec_busy", {31'd0, o_busy}, 32'd1);
        chk("exec_alu_a", {25'd0, o_alu_a}, {25'd0, v.exp_id ? v.a1 : v.a0});
        chk("exec_alu_b", {25'd0, o_alu_b}, {25'd0, v.exp_id ? v.b1 : v.b0});
        chk("exec_alu_op", {29'd0, o_alu_op}, {29'd0, v.exp_id ? v.op1 : v.op0});
        @(negedge i_clk);
        chk("capt_alu_en", {31'd0, o_alu_en}, 32'd0);
        chk("capt_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        @(negedge i_clk);
        chk("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
        chk("rsp_id", {31'd0, o_rsp_id}, {31'd0, v.exp_id});
        chk("rsp_result", {25'd0, o_rsp_result}, {25'd0, v.exp_res});
        chk("rsp_flag", {31'd0, o_rsp_flag}, {31'd0, v.exp_flag});
        @(negedge i_clk);
        exp_ops = exp_ops + 8'd1;
        chk("post_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("post_busy", {31'd0, o_busy}, 32'd0);
        chk("ops_done", {24'd0, o_ops_done}, {24'd0, exp_ops});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_alu_en"}, {31'd0, o_alu_en}, 32'd0);
        chk({tag, "_alu_a"}, {25'd0, o_alu_a}, 32'd0);
        chk({tag, "_alu_b"}, {25'd0, o_alu_b}, 32'd0);
        chk({tag, "_alu_op"}, {29'd0, o_alu_op}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
        chk({tag, "_rsp_id"}, {31'd0, o_rsp_id}, 32'd0);
        chk({tag, "_rsp_result"}, {25'd0, o_rsp_result}, 32'd0);
        chk({tag, "_rsp_flag"}, {31'd0, o_rsp_flag}, 32'd0);
        chk({tag, "_ops_done"}, {24'd0, o_ops_done}, 32'd0);
    endtask

    vec_t tbl[8];
    vec_t v;

    initial begin
        // Round-robin history: last_grant starts at 1, so the first tie goes to req0.
        //         v0    v1    a0  b0  op0   a1  b1  op1   id    res     flag
        tbl[0] = '{1'b1, 1'b0, 5,  3,  3'd0, 0,  0,  3'd0, 1'b0, 7'd8,   1'b1};
        tbl[1] = '{1'b1, 1'b1, 1,  2,  3'd0, 10, 3,  3'd1, 1'b1, 7'd7,   1'b1};
        tbl[2] = '{1'b1, 1'b1, 6,  3,  3'd2, 9,  9,  3'd0, 1'b0, 7'd2,   1'b1};
        tbl[3] = '{1'b1, 1'b1, 7,  7,  3'd0, 12, 10, 3'd3, 1'b1, 7'd14,  1'b1};
        tbl[4] = '{1'b0, 1'b1, 0,  0,  3'd0, 4,  4,  3'd1, 1'b1, 7'd0,   1'b0};
        tbl[5] = '{1'b1, 1'b1, 2,  5,  3'd1, 8,  8,  3'd0, 1'b0, 7'd125, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 127, 1, 3'd0, 0,  0,  3'd0, 1'b0, 7'd0,   1'b0};
        tbl[7] = '{1'b0, 1'b1, 0,  0,  3'd0, 5,  3,  3'd4, 1'b1, 7'd6,   1'b1};

        i_reset = 1'b1;
        i_rsp_ready = 1'b1;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        i_req0_a = '0; i_req0_b = '0; i_req0_op = '0;
        i_req1_a = '0; i_req1_b = '0; i_req1_op = '0;
        i_alu_result = '0;
        i_alu_flag_gt_zero = 1'b0;
        repeat (2) @(negedge i_clk);
        chk_reset_vals("por");
        chk("por_ready0", {31'd0, o_req0_ready}, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);

        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        // Response stall: consumer not ready for 5 cycles, both requesters waiting.
        i_rsp_ready = 1'b0;
        v = '{1'b1, 1'b1, 3, 4, 3'd0, 1, 1, 3'd0, 1'b0, 7'd7, 1'b1};
        drive(v);
        #1;
        chk("stall_grant0", {31'd0, o_req0_ready}, 32'd1);
        @(posedge i_clk);
        repeat (3) @(negedge i_clk);
        chk("stall_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("stall_hold_valid", {31'd0, o_rsp_valid}, 32'd1);
            chk("stall_hold_result", {25'd0, o_rsp_result}, 32'd7);
            chk("stall_hold_id", {31'd0, o_rsp_id}, 32'd0);
            chk("stall_ready0", {31'd0, o_req0_ready}, 32'd0);
            chk("stall_ready1", {31'd0, o_req1_ready}, 32'd0);
            chk("stall_ops_done", {24'd0, o_ops_done}, {24'd0, exp_ops});
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        exp_ops = exp_ops + 8'd1;
        chk("stall_release_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("stall_release_busy", {31'd0, o_busy}, 32'd0);
        chk("stall_release_ops", {24'd0, o_ops_done}, {24'd0, exp_ops});
        chk("stall_next_ready1", {31'd0, o_req1_ready}, 32'd1);
        chk("stall_next_ready0", {31'd0, o_req0_ready}, 32'd0);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;

        // Reset while in EXEC.
        @(negedge i_clk);
        v = '{1'b0, 1'b1, 0, 0, 3'd0, 9, 1, 3'd0, 1'b1, 7'd10, 1'b1};
        drive(v);
        @(posedge i_clk);
        @(negedge i_clk);
        i_req1_valid = 1'b0;
        chk("pre_rst_exec_alu_en", {31'd0, o_alu_en}, 32'd1);
        i_reset = 1'b1;
        #1;
        exp_ops = 8'd0;
        chk_reset_vals("rst_exec");
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("rst_exec_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        end

        // Reset while in RESP.
        i_rsp_ready = 1'b0;
        v = '{1'b1, 1'b0, 2, 2, 3'd0, 0, 0, 3'd0, 1'b0, 7'd4, 1'b1};
        drive(v);
        @(posedge i_clk);
        @(negedge i_clk);
        i_req0_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("pre_rst_resp_valid", {31'd0, o_rsp_valid}, 32'd1);
        i_reset = 1'b1;
        #1;
        chk_reset_vals("rst_resp");
        @(negedge i_clk);
        i_reset = 1'b0;
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        chk("rst_resp_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        v = '{1'b1, 1'b1, 1, 1, 3'd0, 6, 6, 3'd0, 1'b0, 7'd2, 1'b1};
        run_op(v);

        // Counter wrap: ops_done 255 -> 0.
        v = '{1'b1, 1'b0, 1, 0, 3'd0, 0, 0, 3'd0, 1'b0, 7'd1, 1'b1};
        while (exp_ops != 8'd255) run_op(v);
        chk("wrap_at_255", {24'd0, o_ops_done}, 32'd255);
        run_op(v);
        chk("wrap_to_0", {24'd0, o_ops_done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
